// File: rtl/ecpu_pkg.sv
// Shared types and constants for the eCPU pipeline control logic.
package ecpu_pkg;

    typedef enum logic [1:0] {
        FORWARD_NONE = 2'b00,
        FORWARD_MEM  = 2'b01,
        FORWARD_WB   = 2'b10
    } forward_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } hazard_state_t;

    localparam int REG_ZERO        = 0;
    localparam int FLUSH_CNT_WIDTH = 4;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forwarding source compare for the instruction sitting in ID.
module fwd_select
    import ecpu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      uses_i,
    input  logic [REG_ADDR_WIDTH-1:0] src_addr_i,
    input  logic                      ex_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_reg_write_i,
    input  logic                      ex_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_reg_write_i,
    output logic [1:0]                sel_o
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    always_comb begin
        src_live = uses_i && (src_addr_i != REG_ADDR_WIDTH'(REG_ZERO));
        // A load in EX has no result yet; load-use stalling covers that case.
        ex_hit   = src_live && ex_valid_i && ex_reg_write_i && !ex_mem_read_i
                   && (src_addr_i == ex_rd_addr_i);
        mem_hit  = src_live && mem_reg_write_i && (src_addr_i == mem_rd_addr_i);

        sel_o = FORWARD_NONE;
        if (ex_hit) begin
            sel_o = FORWARD_MEM;
        end else if (mem_hit) begin
            sel_o = FORWARD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// eCPU hazard controller: registered forwarding selects, load-use and
// data-memory stalls, branch flush sequencing and a stall-cycle counter.
module hazard_ctrl
    import ecpu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic                      ex_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_reg_write_i,
    input  logic                      ex_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                      mem_reg_write_i,
    input  logic                      branch_taken_i,
    input  logic                      dmem_req_i,
    input  logic                      dmem_ack_i,
    output logic [1:0]                forward_a_o,
    output logic [1:0]                forward_b_o,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      stall_ex_o,
    output logic                      bubble_ex_o,
    output logic                      flush_if_o,
    output logic                      flush_id_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o,
    output logic [1:0]                state_o
);

    // Memory handshake: dmem_req_i is held by the MEM stage while an access is
    // outstanding; dmem_ack_i marks the cycle it completes, and the pipeline
    // advances in that same cycle.

    hazard_state_t              state_q, state_d;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    forward_t                   forward_a_q, forward_a_d;
    forward_t                   forward_b_q, forward_b_d;
    logic [CNT_WIDTH-1:0]       stall_cnt_q, stall_cnt_d;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_use;
    logic       mem_stall;

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .uses_i          (id_uses_rs1_i),
        .src_addr_i      (id_rs1_addr_i),
        .ex_valid_i      (ex_valid_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_mem_read_i   (ex_mem_read_i),
        .mem_rd_addr_i   (mem_rd_addr_i),
        .mem_reg_write_i (mem_reg_write_i),
        .sel_o           (sel_a)
    );

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .uses_i          (id_uses_rs2_i),
        .src_addr_i      (id_rs2_addr_i),
        .ex_valid_i      (ex_valid_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_mem_read_i   (ex_mem_read_i),
        .mem_rd_addr_i   (mem_rd_addr_i),
        .mem_reg_write_i (mem_reg_write_i),
        .sel_o           (sel_b)
    );

    always_comb begin
        load_use = id_valid_i && ex_valid_i && ex_mem_read_i && ex_reg_write_i
                   && ((id_uses_rs1_i && (id_rs1_addr_i != REG_ADDR_WIDTH'(REG_ZERO))
                        && (id_rs1_addr_i == ex_rd_addr_i))
                    || (id_uses_rs2_i && (id_rs2_addr_i != REG_ADDR_WIDTH'(REG_ZERO))
                        && (id_rs2_addr_i == ex_rd_addr_i)));
        mem_stall = dmem_req_i && !dmem_ack_i;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        bubble_ex_o = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;

        case (state_q)
            // The ack cycle of MEM_WAIT is evaluated exactly like RUN so a
            // branch held across the wait is serviced as the pipeline releases.
            RUN, MEM_WAIT: begin
                if (state_q == MEM_WAIT && !dmem_ack_i) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end else if (mem_stall) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (branch_taken_i) begin
                    flush_if_o  = 1'b1;
                    flush_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                    state_d     = RUN;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    state_d     = MEM_WAIT;
                    flush_cnt_d = '0;
                end else begin
                    flush_if_o  = 1'b1;
                    flush_id_o  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q == FLUSH_CNT_WIDTH'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase

        // Outstanding requests are discarded while reset is held.
        if (rst_i) begin
            stall_if_o  = 1'b0;
            stall_id_o  = 1'b0;
            stall_ex_o  = 1'b0;
            bubble_ex_o = 1'b0;
            flush_if_o  = 1'b0;
            flush_id_o  = 1'b0;
        end
    end

    always_comb begin
        forward_a_d = forward_a_q;
        forward_b_d = forward_b_q;
        // A bubble entering ID-EX carries no operands; otherwise selects follow ID-EX.
        if (bubble_ex_o) begin
            forward_a_d = FORWARD_NONE;
            forward_b_d = FORWARD_NONE;
        end else if (!stall_id_o) begin
            forward_a_d = forward_t'(sel_a);
            forward_b_d = forward_t'(sel_b);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_if_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            forward_a_q <= FORWARD_NONE;
            forward_b_q <= FORWARD_NONE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            forward_a_q <= forward_a_d;
            forward_b_q <= forward_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign forward_a_o    = forward_a_q;
    assign forward_b_o    = forward_b_q;
    assign stall_cycles_o = stall_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with FLUSH_CYCLES=3 and a 4-bit stall counter.
module tb_hazard_ctrl;
    import ecpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_uses_rs1_i;
    logic       id_uses_rs2_i;
    logic       ex_valid_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_reg_write_i;
    logic       ex_mem_read_i;
    logic [4:0] mem_rd_addr_i;
    logic       mem_reg_write_i;
    logic       branch_taken_i;
    logic       dmem_req_i;
    logic       dmem_ack_i;
    logic [1:0] forward_a_o;
    logic [1:0] forward_b_o;
    logic       stall_if_o;
    logic       stall_id_o;
    logic       stall_ex_o;
    logic       bubble_ex_o;
    logic       flush_if_o;
    logic       flush_id_o;
    logic [3:0] stall_cycles_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .FLUSH_CYCLES  (3),
        .CNT_WIDTH     (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_uses_rs1_i  (id_uses_rs1_i),
        .id_uses_rs2_i  (id_uses_rs2_i),
        .ex_valid_i     (ex_valid_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_reg_write_i (ex_reg_write_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_reg_write_i(mem_reg_write_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .forward_a_o    (forward_a_o),
        .forward_b_o    (forward_b_o),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .stall_ex_o     (stall_ex_o),
        .bubble_ex_o    (bubble_ex_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .stall_cycles_o (stall_cycles_o),
        .state_o        (state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid_i      = 1'b0;
        id_rs1_addr_i   = '0;
        id_rs2_addr_i   = '0;
        id_uses_rs1_i   = 1'b0;
        id_uses_rs2_i   = 1'b0;
        ex_valid_i      = 1'b0;
        ex_rd_addr_i    = '0;
        ex_reg_write_i  = 1'b0;
        ex_mem_read_i   = 1'b0;
        mem_rd_addr_i   = '0;
        mem_reg_write_i = 1'b0;
        branch_taken_i  = 1'b0;
        dmem_req_i      = 1'b0;
        dmem_ack_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        dmem_req_i = 1'b1;
        tick();
        sample();
        checks++;
        if ({forward_a_o, forward_b_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_forward: got %b expected 0000", {forward_a_o, forward_b_o});
        end
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_if_o, flush_id_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_if_o, flush_id_o});
        end
        checks++;
        if (stall_cycles_o !== 4'd0 || state_o !== RUN) begin
            errors++;
            $display("FAIL reset_cnt_state: got cnt=%0d state=%0d expected cnt=0 state=0",
                     stall_cycles_o, state_o);
        end
        tick();
        idle();
        rst_i = 1'b0;
    endtask

    task automatic test_forward();
        logic [4:0] rs1_t [7] = '{5'd5, 5'd3, 5'd0, 5'd5, 5'd9, 5'd9, 5'd6};
        logic [4:0] rs2_t [7] = '{5'd0, 5'd5, 5'd0, 5'd5, 5'd4, 5'd9, 5'd0};
        logic       u1_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       u2_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exv_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0] exrd_t[7] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd4, 5'd9, 5'd6};
        logic       exwr_t[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] mrd_t [7] = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd9, 5'd9, 5'd0};
        logic       mwr_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        // Hand-derived {forward_a, forward_b} for each vector.
        logic [3:0] exp_t [7] = '{4'b0100, 4'b0001, 4'b0000, 4'b0101, 4'b1001, 4'b0010, 4'b0000};
        logic [3:0] exp_v;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            id_valid_i      = 1'b1;
            id_rs1_addr_i   = rs1_t[i];
            id_rs2_addr_i   = rs2_t[i];
            id_uses_rs1_i   = u1_t[i];
            id_uses_rs2_i   = u2_t[i];
            ex_valid_i      = exv_t[i];
            ex_rd_addr_i    = exrd_t[i];
            ex_reg_write_i  = exwr_t[i];
            ex_mem_read_i   = 1'b0;
            mem_rd_addr_i   = mrd_t[i];
            mem_reg_write_i = mwr_t[i];
            exp_q.push_back(exp_t[i]);
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if ({forward_a_o, forward_b_o} !== exp_v) begin
                errors++;
                $display("FAIL forward_vec%0d: got %b expected %b", i, {forward_a_o, forward_b_o}, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid_i     = 1'b1;
        ex_rd_addr_i   = 5'd7;
        ex_reg_write_i = 1'b1;
        ex_mem_read_i  = 1'b1;
        id_valid_i     = 1'b1;
        id_rs1_addr_i  = 5'd7;
        id_uses_rs1_i  = 1'b1;
        sample();
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o} !== 4'b1101) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected 1101",
                     {stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o});
        end
        tick();
        // Load moves to MEM, bubble now in EX.
        ex_valid_i      = 1'b0;
        ex_rd_addr_i    = '0;
        ex_reg_write_i  = 1'b0;
        ex_mem_read_i   = 1'b0;
        mem_rd_addr_i   = 5'd7;
        mem_reg_write_i = 1'b1;
        sample();
        checks++;
        if ({stall_if_o, bubble_ex_o, forward_a_o} !== 4'b0000 || stall_cycles_o !== 4'd1) begin
            errors++;
            $display("FAIL load_use_release: got stall_if/bubble/fwd_a=%b cnt=%0d expected 0000 cnt=1",
                     {stall_if_o, bubble_ex_o, forward_a_o}, stall_cycles_o);
        end
        tick();
        checks++;
        if (forward_a_o !== 2'b10) begin
            errors++;
            $display("FAIL load_use_fwd_wb: got %b expected 10", forward_a_o);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b111
                || state_o !== ((i == 0) ? RUN : MEM_WAIT)) begin
                errors++;
                $display("FAIL mem_wait_cyc%0d: got stalls=%b state=%0d expected 111 state=%0d",
                         i, {stall_if_o, stall_id_o, stall_ex_o}, state_o, (i == 0) ? 0 : 1);
            end
            tick();
        end
        dmem_ack_i = 1'b1;
        sample();
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b000) begin
            errors++;
            $display("FAIL mem_wait_ack: got %b expected 000", {stall_if_o, stall_id_o, stall_ex_o});
        end
        tick();
        idle();
        sample();
        checks++;
        if (state_o !== RUN || stall_cycles_o !== 4'd4) begin
            errors++;
            $display("FAIL mem_wait_after: got state=%0d cnt=%0d expected state=0 cnt=4",
                     state_o, stall_cycles_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        branch_taken_i = 1'b1;
        sample();
        checks++;
        if ({flush_if_o, flush_id_o, bubble_ex_o} !== 3'b111) begin
            errors++;
            $display("FAIL flush_first: got %b expected 111", {flush_if_o, flush_id_o, bubble_ex_o});
        end
        tick();
        branch_taken_i = 1'b0;
        // Load-use pattern that must be ignored while flushing.
        ex_valid_i     = 1'b1;
        ex_rd_addr_i   = 5'd7;
        ex_reg_write_i = 1'b1;
        ex_mem_read_i  = 1'b1;
        id_valid_i     = 1'b1;
        id_rs1_addr_i  = 5'd7;
        id_uses_rs1_i  = 1'b1;
        for (int i = 1; i < 3; i++) begin
            sample();
            checks++;
            if ({flush_if_o, flush_id_o, bubble_ex_o, stall_if_o} !== 4'b1100) begin
                errors++;
                $display("FAIL flush_cyc%0d: got %b expected 1100",
                         i, {flush_if_o, flush_id_o, bubble_ex_o, stall_if_o});
            end
            tick();
        end
        idle();
        sample();
        checks++;
        if ({flush_if_o, flush_id_o} !== 2'b00 || state_o !== RUN) begin
            errors++;
            $display("FAIL flush_end: got flush=%b state=%0d expected 00 state=0",
                     {flush_if_o, flush_id_o}, state_o);
        end
        tick();
    endtask

    task automatic test_branch_mem_wait();
        int flush_n;
        int bub_n;
        do_reset();
        dmem_req_i     = 1'b1;
        branch_taken_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, bubble_ex_o} !== 5'b11100) begin
                errors++;
                $display("FAIL br_wait_cyc%0d: got %b expected 11100",
                         i, {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, bubble_ex_o});
            end
            tick();
        end
        dmem_ack_i = 1'b1;
        sample();
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, bubble_ex_o} !== 6'b000111) begin
            errors++;
            $display("FAIL br_wait_ack: got %b expected 000111",
                     {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, bubble_ex_o});
        end
        tick();
        idle();
        flush_n = 0;
        bub_n   = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            flush_n += int'(flush_if_o);
            bub_n   += int'(bubble_ex_o);
            tick();
        end
        checks++;
        if (flush_n != 2 || bub_n != 0) begin
            errors++;
            $display("FAIL br_wait_tail: got flush_cycles=%0d bubbles=%0d expected 2 and 0", flush_n, bub_n);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        dmem_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checks++;
        if (stall_cycles_o !== 4'd15 || state_o !== MEM_WAIT) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d state=%0d expected cnt=15 state=1", stall_cycles_o, state_o);
        end
        rst_i = 1'b1;
        tick();
        sample();
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_if_o, flush_id_o} !== 6'b0
            || stall_cycles_o !== 4'd0 || state_o !== RUN) begin
            errors++;
            $display("FAIL reset_mid_wait: got ctrl=%b cnt=%0d state=%0d expected 000000 cnt=0 state=0",
                     {stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_if_o, flush_id_o},
                     stall_cycles_o, state_o);
        end
        tick();
        rst_i = 1'b0;
        idle();
        sample();
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, forward_a_o, forward_b_o} !== 7'b0 || state_o !== RUN) begin
            errors++;
            $display("FAIL after_reset_release: got %b state=%0d expected 0000000 state=0",
                     {stall_if_o, stall_id_o, stall_ex_o, forward_a_o, forward_b_o}, state_o);
        end
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_flush();
        test_branch_mem_wait();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
